seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, handshaked successor to the single-cycle integer ALU in the CPU datapath.
- Executes the RV32I/RV64I ALU operations with a registered result, one cycle after acceptance.
- Also executes the RISC-V M-extension operations iteratively over XLEN cycles.
- Sits in the EX stage; the pipeline stalls on in_ready/out_valid.

Parameters:
- XLEN, 32, operand/result width; 32 or 64.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- flush  in  1  abort in-flight op; has priority over all other inputs
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- func  in  5  operation code (see Behaviour)
- op1  in  XLEN  operand A (rs1)
- op2  in  XLEN  operand B (rs2/imm)
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  result; holds its value while out_valid=1 and out_ready=0

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state goes to IDLE.
  - out_valid=0, result=0, in_ready=1 from the next cycle.
  - Iteration counter and internal registers clear.
  - Reset mid-operation discards the operation with no output.
- func codes:
  - Base ops: 0 ZERO, 1 ADD, 2 SUB, 3 SLL, 4 SLT, 5 XOR, 6 OR, 7 AND, 8 SRL, 9 SRA, 10 SLTU.
  - M ops: 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
  - Codes 19-31 behave as ZERO (result 0, 1-cycle latency).
- Arithmetic rules:
  - Shifts use op2[SHW-1:0] only.
  - SRA is arithmetic on signed op1.
  - SLT and SLTU return a zero-extended 0 or 1.
  - ADD and SUB wrap modulo 2^XLEN.
- Handshake:
  - A request is accepted when in_valid && in_ready.
  - A result transfers when out_valid && out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Back-to-back base ops therefore sustain 1 result per cycle.
- FSM states are IDLE, BUSY, DONE.
  - IDLE, accepted base op: result registered, go to DONE next cycle (latency 1).
  - IDLE, accepted M op: latch operands; take absolute values for signed variants; record sign fixups; counter=XLEN-1; go to BUSY.
  - BUSY: one radix-2 step per cycle, either shift-add multiply or restoring divide. When counter==0, apply the sign fixup, write result, go to DONE. Result appears XLEN+1 cycles after acceptance.
  - DONE, out_ready=1 with no new accept: go to IDLE.
  - DONE, out_ready=1 with a simultaneous accept: treat as acceptance from IDLE in the same edge.
  - DONE, out_ready=0: hold state and result.
- Divide corner cases (results appear at the normal latency):
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give op1.
  - Signed overflow (op1 = -2^(XLEN-1), op2 = -1): DIV gives op1; REM gives 0.
- MUL returns the low XLEN bits. MULH, MULHSU and MULHU return the high XLEN bits of the 2*XLEN product.
- flush=1: state goes to IDLE and out_valid=0 next cycle; any accept in that cycle is ignored.

Optional Feature:
- Macro: SEQ_ALU_FAST_MUL_EN.
- Defined:
  - MUL* ops use a single-cycle combinational 2*XLEN multiplier, registered like base ops (latency 1, never BUSY).
  - DIV/REM remain iterative.
- Undefined: all M ops are iterative as specified above. Area is minimal.

Decomposition:
- Shared package alu_pkg holds:
  - the func code localparams (ZERO..REMU) as a 5-bit enum/typedef alu_func_t;
  - the FSM state typedef;
  - helpers is_mdu(func) and is_signed_variant(func).
- One natural sub-module: seq_alu_mdu.
  - Iterative multiply/divide datapath with start/done pulses and sign fixup.
  - seq_alu keeps the handshake FSM and the base-op datapath.

Test Plan:
- XLEN=32, ADD 0x7FFFFFFF+1 with out_ready=1 -> out_valid 1 cycle later, result 0x80000000; SRA 0x80000000 by op2=0x24 -> 0xF8000000 (shift 4).
- 8 back-to-back base ops with in_valid and out_ready held high -> 8 results on 8 consecutive cycles; in_ready never drops.
- MULH 0xFFFFFFFF * 0xFFFFFFFF -> 0x00000000 after 33 cycles; MULHU of the same operands -> 0xFFFFFFFE; MUL -> 0x00000001.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7; DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF.
- out_ready held 0 for 5 cycles in DONE -> result and out_valid stable, in_ready=0; release -> single transfer.
- Assert rst_n=0 (or flush=1) at BUSY cycle 10 of a DIVU -> no out_valid, in_ready=1 next cycle; a following ADD 2+3 -> 5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: operation codes, FSM state
// encoding and small decode helpers used by the top and the M-unit.
package alu_pkg;

   // Operation codes; 19..31 are unused and decode as ZERO.
   typedef enum logic [4:0] {
      ZERO   = 5'd0,
      ADD    = 5'd1,
      SUB    = 5'd2,
      SLL    = 5'd3,
      SLT    = 5'd4,
      XOR    = 5'd5,
      OR     = 5'd6,
      AND    = 5'd7,
      SRL    = 5'd8,
      SRA    = 5'd9,
      SLTU   = 5'd10,
      MUL    = 5'd11,
      MULH   = 5'd12,
      MULHSU = 5'd13,
      MULHU  = 5'd14,
      DIV    = 5'd15,
      DIVU   = 5'd16,
      REM    = 5'd17,
      REMU   = 5'd18
   } alu_func_t;

   // Handshake FSM state encoding.
   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t BUSY = 2'd1;
   localparam state_t DONE = 2'd2;

   // Any multiply or divide/remainder op.
   function automatic logic is_mdu(input logic [4:0] func);
      return (func >= MUL) && (func <= REMU);
   endfunction

   // Divide/remainder ops only.
   function automatic logic is_div(input logic [4:0] func);
      return (func >= DIV) && (func <= REMU);
   endfunction

   // Ops that treat op1 as signed (MULHSU is signed only on op1).
   function automatic logic is_signed_variant(input logic [4:0] func);
      return func inside {MULH, MULHSU, DIV, REM};
   endfunction

   // Ops that treat op2 as signed.
   function automatic logic is_op2_signed(input logic [4:0] func);
      return func inside {MULH, DIV, REM};
   endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// Iterative multiply/divide unit. A start pulse latches operand magnitudes
// and sign fixup; one radix-2 step (shift-add multiply or restoring divide)
// runs per cycle for XLEN cycles. done pulses together with the final,
// sign-corrected result on the cycle the last step executes.
module seq_alu_mdu
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            start,
   input  logic [4:0]      func,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int SHW = $clog2(XLEN);

   // acc: high product half / partial remainder.
   // lo : low product half (multiplier bits shift out) / dividend->quotient.
   // a  : multiplicand / divisor magnitude.
   logic            busy_q, busy_d;
   logic [SHW-1:0]  cnt_q, cnt_d;
   logic            div_q, div_d;
   logic            hi_q, hi_d;
   logic            rem_q, rem_d;
   logic            neg_q, neg_d;
   logic [XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] a_q, a_d;

   logic            neg1, neg2;
   logic [XLEN-1:0] abs1, abs2;
   logic [XLEN:0]   mul_sum, div_sh, div_diff;
   logic [XLEN-1:0] acc_step, lo_step;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0] sel;

   assign neg1 = is_signed_variant(func) && op1[XLEN-1];
   assign neg2 = is_op2_signed(func) && op2[XLEN-1];
   assign abs1 = neg1 ? -op1 : op1;
   assign abs2 = neg2 ? -op2 : op2;

   assign done = busy_q && (cnt_q == '0);

   // One radix-2 step of whichever operation is in flight.
   always_comb begin
      mul_sum  = {1'b0, acc_q} + {1'b0, {XLEN{lo_q[0]}} & a_q};
      div_sh   = {acc_q, lo_q[XLEN-1]};
      div_diff = div_sh - {1'b0, a_q};
      if (div_q) begin
         if (!div_diff[XLEN]) begin
            acc_step = div_diff[XLEN-1:0];
            lo_step  = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            acc_step = div_sh[XLEN-1:0];
            lo_step  = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         acc_step = mul_sum[XLEN:1];
         lo_step  = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // Sign fixup and half/quotient/remainder select on the final step.
   always_comb begin
      prod = {acc_step, lo_step};
      if (neg_q) prod = -prod;
      sel = rem_q ? acc_step : lo_step;
      if (neg_q) sel = -sel;
      if (div_q) result = sel;
      else       result = hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
   end

   // Operand capture on start, step/count while busy, abort on flush.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      busy_d = busy_q;
      cnt_d  = cnt_q;
      div_d  = div_q;
      hi_d   = hi_q;
      rem_d  = rem_q;
      neg_d  = neg_q;
      acc_d  = acc_q;
      lo_d   = lo_q;
      a_d    = a_q;
      if (flush) begin
         busy_d = 1'b0;
      end else if (start) begin
         busy_d = 1'b1;
         cnt_d  = SHW'(XLEN - 1);
         div_d  = is_div(func);
         hi_d   = (func != MUL);
         rem_d  = func inside {REM, REMU};
         acc_d  = '0;
         if (is_div(func)) begin
            a_d   = abs2;
            lo_d  = abs1;
            // Divide by zero keeps the all-ones quotient unnegated;
            // the remainder always follows the dividend's sign.
            neg_d = (func == REM) ? neg1 : ((neg1 ^ neg2) && (op2 != '0));
         end else begin
            a_d   = abs1;
            lo_d  = abs2;
            neg_d = neg1 ^ neg2;
         end
      end else if (busy_q) begin
         acc_d = acc_step;
         lo_d  = lo_step;
         cnt_d = cnt_q - SHW'(1);
         if (cnt_q == '0) busy_d = 1'b0;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, and every
      // register here (datapath included) is cleared so reset leaves no stale op.
      if (!rst_n) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         div_q  <= 1'b0;
         hi_q   <= 1'b0;
         rem_q  <= 1'b0;
         neg_q  <= 1'b0;
         acc_q  <= '0;
         lo_q   <= '0;
         a_q    <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         hi_q   <= hi_d;
         rem_q  <= rem_d;
         neg_q  <= neg_d;
         acc_q  <= acc_d;
         lo_q   <= lo_d;
         a_q    <= a_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU for the EX stage. Base RV32I/RV64I ops produce a
// registered result one cycle after acceptance; M-extension ops run in the
// iterative seq_alu_mdu and finish XLEN+1 cycles after acceptance.
// Build option: define SEQ_ALU_FAST_MUL_EN to execute MUL/MULH/MULHSU/MULHU
// on a single-cycle combinational multiplier (divides stay iterative).
module seq_alu
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      func,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   localparam int SHW = $clog2(XLEN);

   state_t          state_q, state_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            accept;
   logic            iterative;
   logic            mdu_start;
   logic            mdu_done;
   logic [XLEN-1:0] mdu_result;
   logic [XLEN-1:0] base_result;
   logic [SHW-1:0]  shamt;

   assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
   assign accept    = in_valid && in_ready && !flush;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign shamt     = op2[SHW-1:0];

`ifdef SEQ_ALU_FAST_MUL_EN
   logic [2*XLEN-1:0] mul_a, mul_b, mul_full;
   assign mul_a     = {{XLEN{is_signed_variant(func) & op1[XLEN-1]}}, op1};
   assign mul_b     = {{XLEN{is_op2_signed(func) & op2[XLEN-1]}}, op2};
   assign mul_full  = mul_a * mul_b;
   assign iterative = is_div(func);
`else
   assign iterative = is_mdu(func);
`endif

   // Single-cycle datapath for base ops (and fast multiplies when enabled).
   always_comb begin
      case (func)
         ADD:  base_result = op1 + op2;
         SUB:  base_result = op1 - op2;
         SLL:  base_result = op1 << shamt;
         SLT:  base_result = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
         XOR:  base_result = op1 ^ op2;
         OR:   base_result = op1 | op2;
         AND:  base_result = op1 & op2;
         SRL:  base_result = op1 >> shamt;
         SRA:  base_result = $unsigned($signed(op1) >>> shamt);
         SLTU: base_result = {{(XLEN-1){1'b0}}, op1 < op2};
`ifdef SEQ_ALU_FAST_MUL_EN
         MUL:                  base_result = mul_full[XLEN-1:0];
         MULH, MULHSU, MULHU:  base_result = mul_full[2*XLEN-1:XLEN];
`endif
         default: base_result = '0;
      endcase
   end

   seq_alu_mdu #(
      .XLEN(XLEN)
   ) u_mdu (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .start  (mdu_start),
      .func   (func),
      .op1    (op1),
      .op2    (op2),
      .done   (mdu_done),
      .result (mdu_result)
   );

   // Handshake FSM: accept, wait for the M-unit, hold the result until taken.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      mdu_start = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if ((state_q == DONE) && out_ready) state_d = IDLE;
               if (accept) begin
                  if (iterative) begin
                     mdu_start = 1'b1;
                     state_d   = BUSY;
                  end else begin
                     result_d = base_result;
                     state_d  = DONE;
                  end
               end
            end
            BUSY: begin
               if (mdu_done) begin
                  result_d = mdu_result;
                  state_d  = DONE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // FSM and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (XLEN=32). Expected results are queued when
// a request is accepted and compared by a monitor when the result transfers.
`timescale 1ns/1ps
module tb_seq_alu;
   import alu_pkg::*;

   localparam int XLEN = 32;
`ifdef SEQ_ALU_FAST_MUL_EN
   localparam int MUL_LAT = 1;
`else
   localparam int MUL_LAT = XLEN + 1;
`endif
   localparam int DIV_LAT = XLEN + 1;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
   logic [4:0]  func;
   logic [31:0] op1, op2, result;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_v;

   always #5 clk = ~clk;

   seq_alu #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .func      (func),
      .op1       (op1),
      .op2       (op2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   // Reference model of the ALU operations.
   function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      logic [63:0] sa, sb, ua, ub;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (f)
         ADD:    return a + b;
         SUB:    return a - b;
         SLL:    return a << b[4:0];
         SLT:    return {31'b0, $signed(a) < $signed(b)};
         XOR:    return a ^ b;
         OR:     return a | b;
         AND:    return a & b;
         SRL:    return a >> b[4:0];
         SRA:    return $signed(a) >>> b[4:0];
         SLTU:   return {31'b0, a < b};
         MUL:    begin p = ua * ub; return p[31:0]; end
         MULH:   begin p = sa * sb; return p[63:32]; end
         MULHSU: begin p = sa * ub; return p[63:32]; end
         MULHU:  begin p = ua * ub; return p[63:32]; end
         DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return $signed(a) / $signed(b);
         end
         DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         REMU:   return (b == 0) ? a : a % b;
         default: return 32'h0;
      endcase
   endfunction

   // Scoreboard: compare every transferred result with the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: result=%h, expected no output", result);
         end else begin
            exp_v = exp_q.pop_front();
            if (result !== exp_v) begin
               n_fail++;
               $display("FAIL result: got %h, expected %h", result, exp_v);
            end
         end
      end
   end

   // Present a request (called just after a rising edge); returns just after the accepting edge.
   task automatic issue(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
      int k = 0;
      func = f; op1 = a; op2 = b; in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      n_tests++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL issue_timeout: in_ready=%b, expected 1", in_ready);
      end else begin
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Count falling edges until out_valid is seen (bounded).
   task automatic wait_valid(output int lat);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
   endtask

   // Wait for every queued expectation to be consumed (bounded).
   task automatic drain(input string name);
      int k = 0;
      #1;
      while (exp_q.size() != 0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk); #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d results outstanding, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      func = 5'd0; op1 = '0; op2 = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
      n_tests++;
      if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h, expected 0", result); end
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_add_sra();
      int lat;
      out_ready = 1'b1;
      issue(ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000);
      wait_valid(lat);
      n_tests++;
      if (lat != 1) begin n_fail++; $display("FAIL add_latency: got %0d, expected 1", lat); end
      drain("add");
      issue(SRA, 32'h8000_0000, 32'h24, 32'hF800_0000);
      wait_valid(lat);
      n_tests++;
      if (lat != 1) begin n_fail++; $display("FAIL sra_latency: got %0d, expected 1", lat); end
      drain("sra");
   endtask

   task automatic test_back_to_back();
      logic [4:0]  ops [8];
      logic [31:0] a, b;
      ops = '{ADD, SUB, SLL, SLT, SRA, SLTU, XOR, 5'd25};
      out_ready = 1'b1;
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin
            a = $urandom; b = $urandom;
            func = ops[i]; op1 = a; op2 = b; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (i < 8) begin
            n_tests++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b, expected 1", i, in_ready); end
            exp_q.push_back(model(ops[i], a, b));
         end
         if (i > 0) begin
            n_tests++;
            if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid[%0d]: got %b, expected 1", i, out_valid); end
         end
         @(posedge clk); #1;
      end
      drain("b2b");
   endtask

   task automatic test_mul();
      logic [4:0]  fs [3];
      logic [31:0] es [3];
      int lat;
      fs = '{MULH, MULHU, MUL};
      es = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         issue(fs[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, es[i]);
         wait_valid(lat);
         n_tests++;
         if (lat != MUL_LAT) begin n_fail++; $display("FAIL mul_latency[%0d]: got %0d, expected %0d", i, lat, MUL_LAT); end
         drain("mul");
      end
   endtask

   task automatic test_div();
      logic [4:0]  fs [6];
      logic [31:0] as [6];
      logic [31:0] bs [6];
      logic [31:0] es [6];
      int lat;
      fs = '{DIV, REM, DIVU, REMU, DIV, REM};
      as = '{32'h8000_0000, 32'h8000_0000, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
      bs = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd2, 32'd2};
      es = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         issue(fs[i], as[i], bs[i], es[i]);
         wait_valid(lat);
         n_tests++;
         if (lat != DIV_LAT) begin n_fail++; $display("FAIL div_latency[%0d]: got %0d, expected %0d", i, lat, DIV_LAT); end
         drain("div");
      end
   endtask

   task automatic test_stall();
      int lat;
      out_ready = 1'b0;
      issue(XOR, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FF0_0FF0);
      wait_valid(lat);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         n_tests++;
         if (out_valid !== 1'b1 || result !== 32'h0FF0_0FF0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: out_valid=%b result=%h in_ready=%b, expected 1 0ff00ff0 0",
                     i, out_valid, result, in_ready);
         end
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL stall_release: out_valid=%b pending=%0d, expected 0 0", out_valid, exp_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_abort(input bit use_flush);
      bit saw;
      int lat;
      out_ready = 1'b1;
      issue(DIVU, 32'd100, 32'd7, 32'd14);
      void'(exp_q.pop_back());
      repeat (9) @(posedge clk);
      #1;
      if (use_flush) begin
         flush = 1'b1; in_valid = 1'b1; func = ADD; op1 = 32'd1; op2 = 32'd1;
      end else begin
         rst_n = 1'b0;
      end
      @(posedge clk); #1;
      flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL abort%0d_state: out_valid=%b in_ready=%b, expected 0 1", use_flush, out_valid, in_ready);
      end
      saw = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw = 1'b1;
      end
      n_tests++;
      if (saw) begin n_fail++; $display("FAIL abort%0d_no_output: out_valid seen=1, expected 0", use_flush); end
      @(posedge clk); #1;
      issue(ADD, 32'd2, 32'd3, 32'd5);
      wait_valid(lat);
      drain("abort_add");
   endtask

   task automatic test_random();
      logic [4:0]  f;
      logic [31:0] a, b;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         f = 5'($urandom_range(0, 20));
         a = $urandom;
         b = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         issue(f, a, b, model(f, a, b));
         drain("random");
      end
   endtask

   initial begin
      #900us;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_add_sra();
      test_back_to_back();
      test_mul();
      test_div();
      test_stall();
      test_abort(1'b0);
      test_abort(1'b1);
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
